// File: rtl/bcd_time_to_seconds.sv
// Converts a 12-hour BCD time plus PM flag into the seconds-of-day count used by the
// time counters (count 0 = 01:00 AM) using a serial shift-add datapath with start/done handshake.
`timescale 1ns/1ps
module bcd_time_to_seconds #(
    parameter int BIT_WIDTH   = 17,
    parameter int MAX_COUNT   = 86400,
    parameter int HOUR_OFFSET = 23
) (
    input  logic                 i_Clk_5MHz,
    input  logic                 i_Reset,
    input  logic                 i_Start,
    input  logic [15:0]          i_Time,
    input  logic                 i_PM,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic                 o_Error,
    output logic [BIT_WIDTH-1:0] o_Seconds
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_VALIDATE = 3'd1,
        S_MUL_H    = 3'd2,
        S_MUL_M    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [BIT_WIDTH-1:0] MAX_COUNT_W = BIT_WIDTH'(MAX_COUNT);
    localparam logic [BIT_WIDTH-1:0] SEC_PER_HOUR = BIT_WIDTH'(3600);
    localparam logic [BIT_WIDTH-1:0] SEC_PER_MIN  = BIT_WIDTH'(60);

    state_t                state_r;
    state_t                state_next_s;
    logic [15:0]           time_r;
    logic                  pm_r;
    logic                  err_r;
    logic [4:0]            hour_r;
    logic [5:0]            min_r;
    logic [2:0]            step_r;
    logic [BIT_WIDTH-1:0]  addend_r;
    logic [BIT_WIDTH-1:0]  acc_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  error_r;
    logic [BIT_WIDTH-1:0]  seconds_r;

    logic [4:0]            hour12_s;
    logic [4:0]            hour24_s;
    logic [5:0]            hour_sum_s;
    logic [4:0]            hour_int_s;
    logic [5:0]            minutes_s;
    logic                  legal_s;

    function automatic logic digit_le(input logic [3:0] digit, input logic [3:0] limit);
        return (digit <= limit);
    endfunction

    // Decode captured BCD into legality, offset internal hour and binary minutes
    always_comb begin
        hour12_s   = 5'd0;
        hour24_s   = 5'd0;
        hour_sum_s = 6'd0;
        hour_int_s = 5'd0;
        minutes_s  = 6'd0;
        legal_s    = 1'b0;

        if (time_r[15:12] == 4'd1) begin
            hour12_s = 5'd10 + {1'b0, time_r[11:8]};
        end else begin
            hour12_s = {1'b0, time_r[11:8]};
        end

        legal_s = digit_le(time_r[15:12], 4'd1) && digit_le(time_r[11:8], 4'd9) &&
                  (hour12_s >= 5'd1) && (hour12_s <= 5'd12) &&
                  digit_le(time_r[7:4], 4'd5) && digit_le(time_r[3:0], 4'd9);

        // 12 AM is hour 0, 12 PM is hour 12
        if (hour12_s == 5'd12) begin
            hour24_s = pm_r ? 5'd12 : 5'd0;
        end else begin
            hour24_s = pm_r ? (hour12_s + 5'd12) : hour12_s;
        end

        hour_sum_s = {1'b0, hour24_s} + 6'(HOUR_OFFSET);
        if (hour_sum_s >= 6'd24) begin
            hour_int_s = 5'(hour_sum_s - 6'd24);
        end else begin
            hour_int_s = hour_sum_s[4:0];
        end

        minutes_s = {time_r[6:4], 3'b000} + {2'b00, time_r[6:4], 1'b0} + {2'b00, time_r[3:0]};
    end

    // State register
    always_ff @(posedge i_Clk_5MHz or posedge i_Reset) begin
        if (i_Reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (i_Start) begin
                    state_next_s = S_VALIDATE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_VALIDATE: begin
                if (legal_s) begin
                    state_next_s = S_MUL_H;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            S_MUL_H: begin
                if (step_r == 3'd4) begin
                    state_next_s = S_MUL_M;
                end else begin
                    state_next_s = S_MUL_H;
                end
            end
            S_MUL_M: begin
                if (step_r == 3'd5) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_MUL_M;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Capture, validation result and serial shift-add accumulation
    always_ff @(posedge i_Clk_5MHz or posedge i_Reset) begin
        if (i_Reset) begin
            time_r   <= 16'h0000;
            pm_r     <= 1'b0;
            err_r    <= 1'b0;
            hour_r   <= 5'd0;
            min_r    <= 6'd0;
            step_r   <= 3'd0;
            addend_r <= '0;
            acc_r    <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (i_Start) begin
                        time_r <= i_Time;
                        pm_r   <= i_PM;
                    end
                end
                S_VALIDATE: begin
                    err_r    <= ~legal_s;
                    hour_r   <= hour_int_s;
                    min_r    <= minutes_s;
                    step_r   <= 3'd0;
                    addend_r <= SEC_PER_HOUR;
                    acc_r    <= '0;
                end
                S_MUL_H: begin
                    if (hour_r[0]) begin
                        acc_r <= acc_r + addend_r;
                    end
                    hour_r <= {1'b0, hour_r[4:1]};
                    // Last hour bit: re-seed the addend for the minutes pass
                    if (step_r == 3'd4) begin
                        step_r   <= 3'd0;
                        addend_r <= SEC_PER_MIN;
                    end else begin
                        step_r   <= step_r + 3'd1;
                        addend_r <= {addend_r[BIT_WIDTH-2:0], 1'b0};
                    end
                end
                S_MUL_M: begin
                    if (min_r[0]) begin
                        acc_r <= acc_r + addend_r;
                    end
                    min_r    <= {1'b0, min_r[5:1]};
                    step_r   <= step_r + 3'd1;
                    addend_r <= {addend_r[BIT_WIDTH-2:0], 1'b0};
                end
                S_DONE: begin
                    step_r <= 3'd0;
                end
                default: begin
                    step_r <= 3'd0;
                end
            endcase
        end
    end

    // Registered handshake outputs; out-of-range accumulator is reported as an error
    always_ff @(posedge i_Clk_5MHz or posedge i_Reset) begin
        if (i_Reset) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            seconds_r <= '0;
        end else begin
            busy_r <= (state_next_s != S_IDLE);
            if (state_r == S_DONE) begin
                done_r <= 1'b1;
                if (err_r || (acc_r >= MAX_COUNT_W)) begin
                    error_r <= 1'b1;
                end else begin
                    error_r   <= 1'b0;
                    seconds_r <= acc_r;
                end
            end else begin
                done_r  <= 1'b0;
                error_r <= 1'b0;
            end
        end
    end

    assign o_Busy    = busy_r;
    assign o_Done    = done_r;
    assign o_Error   = error_r;
    assign o_Seconds = seconds_r;

endmodule

// File: tb/tb_bcd_time_to_seconds.sv
// Scoreboard bench for bcd_time_to_seconds: driver pushes expected results from an
// arithmetic reference model, monitor pops and compares on every o_Done pulse.
`timescale 1ns/1ps
module tb_bcd_time_to_seconds;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] tim;
    logic        pm;
    logic        busy;
    logic        done;
    logic        err;
    logic [16:0] secs;

    always #100 clk = ~clk;

    bcd_time_to_seconds #(
        .BIT_WIDTH(17), .MAX_COUNT(86400), .HOUR_OFFSET(23)
    ) dut (
        .i_Clk_5MHz(clk),
        .i_Reset   (rst),
        .i_Start   (start),
        .i_Time    (tim),
        .i_PM      (pm),
        .o_Busy    (busy),
        .o_Done    (done),
        .o_Error   (err),
        .o_Seconds (secs)
    );

    typedef struct {
        logic [15:0] t;
        logic        p;
        logic        e;
        logic [16:0] s;
        int          k;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [16:0] model_secs = 17'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    // Reference: legality from BCD digits, then plain 24-hour arithmetic
    function automatic void model(input logic [15:0] t, input logic p,
                                  output logic e, output int s);
        int h1, h2, m1, m2, hr12, hr24;
        h1 = int'(t[15:12]); h2 = int'(t[11:8]); m1 = int'(t[7:4]); m2 = int'(t[3:0]);
        hr12 = h1 * 10 + h2;
        e = !(h1 <= 1 && h2 <= 9 && m1 <= 5 && m2 <= 9 && hr12 >= 1 && hr12 <= 12);
        hr24 = (hr12 % 12) + (p ? 12 : 0);
        s = ((hr24 + 23) % 24) * 3600 + (m1 * 10 + m2) * 60;
    endfunction

    task automatic push_exp(input logic [15:0] t, input logic p);
        exp_t x;
        logic e;
        int   s;
        model(t, p, e, s);
        if (!e) model_secs = 17'(s);
        x.t = t; x.p = p; x.e = e; x.s = model_secs; x.k = cyc;
        q.push_back(x);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout busy=%0d expected 0", busy);
        end
    endtask

    task automatic issue(input logic [15:0] t, input logic p);
        wait_idle();
        tim = t; pm = p; start = 1'b1;
        @(posedge clk); #1;
        push_exp(t, p);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", q.size(), 0);
    endtask

    // Monitor: compare every completion against the oldest outstanding expectation
    initial begin
        forever begin
            @(posedge clk); #1;
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done seconds=%0d error=%0d expected no completion", secs, err);
                end else begin
                    exp_t x;
                    int   hi, h24, mn, h12;
                    x = q.pop_front();
                    check("latency", cyc - x.k, x.e ? 2 : 13);
                    check("error_flag", err, x.e);
                    check("seconds", secs, x.s);
                    check("busy_at_done", busy, 0);
                    if (!x.e) begin
                        hi  = int'(secs) / 3600;
                        h24 = (hi + 1) % 24;
                        mn  = (int'(secs) % 3600) / 60;
                        h12 = (h24 % 12 == 0) ? 12 : h24 % 12;
                        check("roundtrip_time", to_bcd(h12, mn), x.t);
                        check("roundtrip_pm", (h24 >= 12) ? 1 : 0, x.p);
                    end
                end
            end
        end
    end

    initial begin
        #(200 * 90000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rt;
        rst = 1'b1; start = 1'b0; tim = 16'h0000; pm = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_seconds", secs, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_error", err, 0);

        issue(16'h0100, 1'b0);
        issue(16'h1200, 1'b0);
        issue(16'h1200, 1'b1);
        issue(16'h1159, 1'b1);
        issue(16'h0730, 1'b0);
        issue(16'h1300, 1'b0);
        issue(16'h0015, 1'b1);
        issue(16'h0960, 1'b0);
        issue(16'h1A00, 1'b1);
        drain();

        // Start pulse and input change mid-conversion are ignored
        issue(16'h0730, 1'b0);
        repeat (4) @(negedge clk);
        tim = 16'h1159; pm = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Held start re-triggers exactly when IDLE is re-entered
        wait_idle();
        tim = 16'h0445; pm = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        push_exp(16'h0445, 1'b1);
        @(negedge clk);
        tim = 16'h1030; pm = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        push_exp(16'h1030, 1'b0);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset during the minutes pass clears everything and produces no completion
        issue(16'h0945, 1'b1);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_error", err, 0);
        check("midreset_seconds", secs, 0);
        q.delete();
        model_secs = 17'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(16'h1300, 1'b1);
        drain();

        for (int i = 0; i < 200; i++) begin
            if ($urandom % 2 == 0) begin
                issue(to_bcd(int'($urandom_range(1, 12)), int'($urandom_range(0, 59))), 1'($urandom % 2));
            end else begin
                rt = 16'($urandom);
                issue(rt, 1'($urandom % 2));
            end
        end
        drain();

        for (int p = 0; p < 2; p++) begin
            for (int h = 1; h <= 12; h++) begin
                for (int m = 0; m < 60; m++) begin
                    issue(to_bcd(h, m), 1'(p));
                end
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
